cache_nway_wb: RTL

Parametrised N-way set-associative write-back, write-allocate cache with true-LRU replacement, clocked and handshaked on both sides. Sits between the CPU-side load/store port and the block-wide main-memory model. Replaces the fixed 2-way, single-word, combinational cache with configurable geometry and multi-cycle memory transfers.

---
 rtl/cache_pkg.sv | 46 ++++
 rtl/cache_lru.sv | 52 +++++
 rtl/cache_nway_wb.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache types: controller state encoding, geometry-derived widths and address split helpers.
// Helpers work on 32-bit words so they stay valid when an index or offset field is zero bits wide.
`timescale 1ns/1ps
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOOKUP    = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_t;

  function automatic int calc_off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int words, input int sets);
    return addr_w - $clog2(words) - $clog2(sets);
  endfunction

  // Storage width for a field that may be zero bits wide.
  function automatic int store_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int off_w);
    return a & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int off_w, input int idx_w);
    return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
    return a >> (off_w + idx_w);
  endfunction

  function automatic logic [31:0] blk_addr(input logic [31:0] tag, input logic [31:0] idx, input int idx_w);
    return (tag << idx_w) | idx;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age store per set: accessed way becomes age 0, younger ways age by one; victim is the oldest.
// Update takes effect on the next edge; victim select is combinational on the current set.
`timescale 1ns/1ps
module cache_lru #(
  parameter int SETS = 4,
  parameter int WAYS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_upd,
  input  logic [cache_pkg::store_w(SETS)-1:0]   i_set,
  input  logic [cache_pkg::store_w(WAYS)-1:0]   i_upd_way,
  output logic [cache_pkg::store_w(WAYS)-1:0]   o_victim
);
  import cache_pkg::*;

  localparam int WAY_WS = store_w(WAYS);

  logic [WAY_WS-1:0] r_age [SETS][WAYS];
  logic [WAY_WS-1:0] w_victim;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= WAY_WS'(w);
        end
      end
    end else if (i_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_WS'(w) == i_upd_way) begin
          r_age[i_set][w] <= '0;
        end else if (r_age[i_set][w] < r_age[i_set][i_upd_way]) begin
          r_age[i_set][w] <= r_age[i_set][w] + WAY_WS'(1);
        end
      end
    end
  end

  // Ages form a permutation per set, so exactly one way holds the oldest age.
  always_comb begin
    w_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[i_set][w] == WAY_WS'(WAYS - 1)) begin
        w_victim = WAY_WS'(w);
      end
    end
  end

  assign o_victim = w_victim;

endmodule

// File: rtl/cache_nway_wb.sv
// N-way write-back/write-allocate cache; hit completes the cycle after accept, misses add block transfers.
// CPU side stalls via cpuReady (IDLE only); memory side holds memReq until memAck. Optional counters: CACHE_STATS_EN.
`timescale 1ns/1ps
module cache_nway_wb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cpuReq,
  output logic                                      cpuReady,
  input  logic                                      isRead,
  input  logic [ADDR_W-1:0]                         address,
  input  logic [DATA_W-1:0]                         writeData,
  output logic                                      cpuDone,
  output logic [DATA_W-1:0]                         readData,
  output logic                                      isHit,
  output logic                                      memReq,
  output logic                                      memWrite,
  output logic [ADDR_W-cache_pkg::calc_off_w(WORDS)-1:0] memAddr,
  output logic [DATA_W*WORDS-1:0]                   memWriteData,
  input  logic [DATA_W*WORDS-1:0]                   memReadData,
  input  logic                                      memAck
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                               hitCount,
  output logic [31:0]                               missCount
`endif
);
  import cache_pkg::*;

  localparam int OFF_W   = calc_off_w(WORDS);
  localparam int IDX_W   = calc_idx_w(SETS);
  localparam int TAG_W   = calc_tag_w(ADDR_W, WORDS, SETS);
  localparam int OFF_WS  = store_w(WORDS);
  localparam int IDX_WS  = store_w(SETS);
  localparam int WAY_WS  = store_w(WAYS);
  localparam int BLK_W   = DATA_W * WORDS;
  localparam int MADDR_W = ADDR_W - OFF_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_first;
  logic [WAY_WS-1:0]   r_victim;
  logic                r_mem_req;
  logic                w_mem_req_nxt;
  logic [DATA_W-1:0]   r_read_data;
  logic                r_is_hit;

  logic                r_valid [WAYS][SETS];
  logic                r_dirty [WAYS][SETS];
  logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
  logic [BLK_W-1:0]    r_data  [WAYS][SETS];

  logic [OFF_WS-1:0]   w_off;
  logic [IDX_WS-1:0]   w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic [WAY_WS-1:0]   w_hit_way;
  logic                w_has_inv;
  logic [WAY_WS-1:0]   w_inv_way;
  logic [WAY_WS-1:0]   w_lru_victim;
  logic [WAY_WS-1:0]   w_victim;
  logic [BLK_W-1:0]    w_hit_blk;
  logic [DATA_W-1:0]   w_hit_word;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_done;
  logic                w_lru_upd;
  logic                w_fill;
  logic                w_wr_hit;
  logic [MADDR_W-1:0]  w_victim_blk;
  logic [MADDR_W-1:0]  w_req_blk;

  assign w_off = OFF_WS'(addr_off(32'(r_addr), OFF_W));
  assign w_idx = IDX_WS'(addr_idx(32'(r_addr), OFF_W, IDX_W));
  assign w_tag = TAG_W'(addr_tag(32'(r_addr), OFF_W, IDX_W));

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_WS'(w);
      end
      if (!r_valid[w][w_idx]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_WS'(w);
      end
    end
  end

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .i_upd     (w_lru_upd),
    .i_set     (w_idx),
    .i_upd_way (w_hit_way),
    .o_victim  (w_lru_victim)
  );

  assign w_victim   = w_has_inv ? w_inv_way : w_lru_victim;
  assign w_hit_blk  = r_data[w_hit_way][w_idx];
  assign w_hit_word = w_hit_blk[DATA_W*w_off +: DATA_W];
  assign w_rd_word  = r_is_read ? w_hit_word : r_wdata;

  assign w_victim_blk = MADDR_W'(blk_addr(32'(r_tag[r_victim][w_idx]), 32'(w_idx), IDX_W));
  assign w_req_blk    = MADDR_W'(blk_addr(32'(w_tag), 32'(w_idx), IDX_W));

  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req_nxt = r_mem_req;
    w_done        = 1'b0;
    w_lru_upd     = 1'b0;
    w_fill        = 1'b0;
    w_wr_hit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpuReq) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_done      = 1'b1;
          w_lru_upd   = 1'b1;
          w_wr_hit    = !r_is_read;
          w_state_nxt = S_IDLE;
        end else begin
          w_mem_req_nxt = 1'b1;
          w_state_nxt   = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (r_mem_req && memAck) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        // Entered from WRITEBACK with memReq low: re-raise it one cycle later.
        if (!r_mem_req) begin
          w_mem_req_nxt = 1'b1;
        end else if (memAck) begin
          w_fill        = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_LOOKUP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_first     <= 1'b0;
      r_victim    <= '0;
      r_read_data <= '0;
      r_is_hit    <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
        end
      end
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_mem_req_nxt;
      if ((r_state == S_IDLE) && cpuReq) begin
        r_is_read <= isRead;
        r_addr    <= address;
        r_wdata   <= writeData;
        r_first   <= 1'b1;
      end
      if ((r_state == S_LOOKUP) && !w_hit) begin
        r_victim <= w_victim;
        r_first  <= 1'b0;
      end
      if (w_done) begin
        r_read_data <= w_rd_word;
        r_is_hit    <= r_first;
      end
      if (w_wr_hit) r_dirty[w_hit_way][w_idx] <= 1'b1;
      if (w_fill) begin
        r_valid[r_victim][w_idx] <= 1'b1;
        r_dirty[r_victim][w_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[r_victim][w_idx]  <= w_tag;
      r_data[r_victim][w_idx] <= memReadData;
    end
    if (w_wr_hit) r_data[w_hit_way][w_idx][DATA_W*w_off +: DATA_W] <= r_wdata;
  end

  assign cpuReady     = (r_state == S_IDLE) && !rst;
  assign cpuDone      = w_done;
  assign readData     = w_done ? w_rd_word : r_read_data;
  assign isHit        = w_done ? r_first : r_is_hit;
  assign memReq       = r_mem_req;
  assign memWrite     = (r_state == S_WRITEBACK);
  assign memAddr      = (r_state == S_WRITEBACK) ? w_victim_blk :
                        (r_state == S_ALLOCATE)  ? w_req_blk : '0;
  assign memWriteData = (r_state == S_WRITEBACK) ? r_data[r_victim][w_idx] : '0;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if ((r_state == S_LOOKUP) && r_first) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hitCount  = r_hit_cnt;
  assign missCount = r_miss_cnt;
`endif

endmodule
